// File: rtl/calc_pkg.sv
// Shared opcode encodings, sequencer state type and saturation constants
// for the signed calculator and its sequencer.
package calc_pkg;

   localparam logic [2:0] OP_ADD_AB = 3'b000;
   localparam logic [2:0] OP_SUB_AB = 3'b001;
   localparam logic [2:0] OP_ABS_B  = 3'b010;
   localparam logic [2:0] OP_ADD_BA = 3'b100;
   localparam logic [2:0] OP_SUB_BA = 3'b101;
   localparam logic [2:0] OP_ABS_A  = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Largest positive (positive=1) or most negative (positive=0) value of a
   // w-bit two's-complement number, returned in the low w bits.
   function automatic logic [63:0] sat_const(input int unsigned w, input logic positive);
      logic [63:0] max_val;
      max_val = (64'd1 << (w - 1)) - 64'd1;
      return positive ? max_val : ~max_val;
   endfunction

endpackage

// File: rtl/calc_sat.sv
// Saturation mux for overflowed calculator results. Only instantiated by
// calc_sequencer when CALC_SEQUENCER_SAT_EN is defined.
module calc_sat
   import calc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         is_abs,
   input  logic [W-1:0] r,
   input  logic         ovf,
   output logic [W-1:0] value
);

   localparam logic [W-1:0] SAT_MAX = W'(sat_const(W, 1'b1));
   localparam logic [W-1:0] SAT_MIN = W'(sat_const(W, 1'b0));

   // An overflowed add/sub flips the sign bit, so a set MSB means the true
   // result was positive; abs can only overflow upwards.
   logic positive;
   assign positive = is_abs | r[W-1];

   assign value = ovf ? (positive ? SAT_MAX : SAT_MIN) : r;

endmodule

// File: rtl/calc_sequencer.sv
// Command sequencer around the external combinational signed calculator.
// Optional saturation of overflowed results: define CALC_SEQUENCER_SAT_EN.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int W     = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [2:0]       cmd_op,
   input  logic [W-1:0]     cmd_data,
   output logic [2:0]       calc_op,
   output logic [W-1:0]     calc_a,
   output logic [W-1:0]     calc_b,
   input  logic [W-1:0]     calc_r,
   input  logic             calc_ovf,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W-1:0]     res_data,
   output logic             res_ovf,
   output logic [W-1:0]     acc,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] op_count
);

   state_t       state_reg;
   logic [W-1:0] result;

`ifdef CALC_SEQUENCER_SAT_EN
   calc_sat #(.W(W)) u_sat (
      .is_abs (calc_op[1]),
      .r      (calc_r),
      .ovf    (calc_ovf),
      .value  (result)
   );
`else
   assign result = calc_r;
`endif

   assign cmd_ready = (state_reg == IDLE);
   assign res_valid = (state_reg == RESP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         acc        <= '0;
         calc_op    <= '0;
         calc_a     <= '0;
         calc_b     <= '0;
         res_data   <= '0;
         res_ovf    <= 1'b0;
         sticky_ovf <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_load) begin
                     acc        <= cmd_data;
                     res_data   <= cmd_data;
                     res_ovf    <= 1'b0;
                     sticky_ovf <= 1'b0;
                     state_reg  <= RESP;
                  end else begin
                     calc_op   <= cmd_op;
                     calc_a    <= acc;
                     calc_b    <= cmd_data;
                     state_reg <= EXEC;
                  end
               end
            end
            EXEC: begin
               acc        <= result;
               res_data   <= result;
               res_ovf    <= calc_ovf;
               sticky_ovf <= sticky_ovf | calc_ovf;
               op_count   <= op_count + CNT_W'(1);
               state_reg  <= RESP;
            end
            RESP: begin
               if (res_ready) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Table-driven bench for calc_sequencer with a behavioural W=16 calculator.
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int W     = 16;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid, cmd_ready, cmd_load;
   logic [2:0]       cmd_op, calc_op;
   logic [W-1:0]     cmd_data, calc_a, calc_b, calc_r;
   logic             calc_ovf, res_valid, res_ready, res_ovf, sticky_ovf;
   logic [W-1:0]     res_data, acc;
   logic [CNT_W-1:0] op_count;

   // standalone saturation mux
   logic             s_abs, s_ovf;
   logic [W-1:0]     s_r, s_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   calc_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_op(cmd_op), .cmd_data(cmd_data),
      .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
      .calc_r(calc_r), .calc_ovf(calc_ovf),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_ovf(res_ovf),
      .acc(acc), .sticky_ovf(sticky_ovf), .op_count(op_count)
   );

   calc_sat #(.W(W)) u_sat_chk (.is_abs(s_abs), .r(s_r), .ovf(s_ovf), .value(s_val));

   // Behavioural calculator
   always_comb begin
      logic [W-1:0] s;
      s = '0;
      calc_ovf = 1'b0;
      case (calc_op)
         3'b000, 3'b100: begin
            s = calc_a + calc_b;
            calc_ovf = (calc_a[W-1] == calc_b[W-1]) && (s[W-1] != calc_a[W-1]);
         end
         3'b001: begin
            s = calc_a - calc_b;
            calc_ovf = (calc_a[W-1] != calc_b[W-1]) && (s[W-1] != calc_a[W-1]);
         end
         3'b101: begin
            s = calc_b - calc_a;
            calc_ovf = (calc_b[W-1] != calc_a[W-1]) && (s[W-1] != calc_b[W-1]);
         end
         3'b010, 3'b011: begin
            s = calc_b[W-1] ? -calc_b : calc_b;
            calc_ovf = (calc_b == 16'h8000);
         end
         default: begin
            s = calc_a[W-1] ? -calc_a : calc_a;
            calc_ovf = (calc_a == 16'h8000);
         end
      endcase
      calc_r = s;
   end

`ifdef CALC_SEQUENCER_SAT_EN
   localparam logic [15:0] R3 = 16'h7FFF, R9 = 16'h7FFF, R10 = 16'h7FFE, R15 = 16'h8000;
   localparam logic        O10 = 1'b0;
`else
   localparam logic [15:0] R3 = 16'h8000, R9 = 16'h8000, R10 = 16'h7FFF, R15 = 16'h7FFF;
   localparam logic        O10 = 1'b1;
`endif

   typedef struct {
      logic        load;
      logic [2:0]  op;
      logic [15:0] data;
      logic [15:0] exp_data;
      logic        exp_ovf;
      logic        exp_sticky;
      logic [7:0]  exp_cnt;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " acc"},        32'(acc), 0);
      chk({tag, " calc_op"},    32'(calc_op), 0);
      chk({tag, " calc_a"},     32'(calc_a), 0);
      chk({tag, " calc_b"},     32'(calc_b), 0);
      chk({tag, " res_data"},   32'(res_data), 0);
      chk({tag, " res_ovf"},    32'(res_ovf), 0);
      chk({tag, " res_valid"},  32'(res_valid), 0);
      chk({tag, " sticky_ovf"}, 32'(sticky_ovf), 0);
      chk({tag, " op_count"},   32'(op_count), 0);
      chk({tag, " cmd_ready"},  32'(cmd_ready), 1);
   endtask

   // Issue one command, wait (bounded) for the response, check it, accept it.
   task automatic run_cmd(input int idx, input vec_t v);
      int lat;
      chk($sformatf("v%0d cmd_ready", idx), 32'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_load  = v.load;
      cmd_op    = v.op;
      cmd_data  = v.data;
      tick();
      cmd_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk($sformatf("v%0d latency", idx), 32'(lat), v.load ? 1 : 2);
      chk($sformatf("v%0d res_data", idx), 32'(res_data), 32'(v.exp_data));
      chk($sformatf("v%0d acc", idx), 32'(acc), 32'(v.exp_data));
      chk($sformatf("v%0d res_ovf", idx), 32'(res_ovf), 32'(v.exp_ovf));
      chk($sformatf("v%0d sticky_ovf", idx), 32'(sticky_ovf), 32'(v.exp_sticky));
      chk($sformatf("v%0d op_count", idx), 32'(op_count), 32'(v.exp_cnt));
      $display("vec %0d: load=%0b op=%03b data=%h -> res=%h ovf=%0b sticky=%0b cnt=%0d lat=%0d",
               idx, v.load, v.op, v.data, res_data, res_ovf, sticky_ovf, op_count, lat);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_data = '0;
      res_ready = 1'b0; s_abs = 1'b0; s_ovf = 1'b0; s_r = '0;

      //          load  op      data      exp_data  ovf   sticky cnt
      vecs[0]  = '{1'b1, 3'b000, 16'd100,  16'd100,  1'b0, 1'b0, 8'd0};
      vecs[1]  = '{1'b0, 3'b000, 16'd23,   16'd123,  1'b0, 1'b0, 8'd1};
      vecs[2]  = '{1'b1, 3'b000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 8'd1};
      vecs[3]  = '{1'b0, 3'b000, 16'd1,    R3,       1'b1, 1'b1, 8'd2};
      vecs[4]  = '{1'b1, 3'b000, 16'd5,    16'd5,    1'b0, 1'b0, 8'd2};
      vecs[5]  = '{1'b1, 3'b000, 16'd10,   16'd10,   1'b0, 1'b0, 8'd2};
      vecs[6]  = '{1'b0, 3'b101, 16'd3,    16'hFFF9, 1'b0, 1'b0, 8'd3};
      vecs[7]  = '{1'b0, 3'b110, 16'd0,    16'd7,    1'b0, 1'b0, 8'd4};
      vecs[8]  = '{1'b1, 3'b000, 16'h8000, 16'h8000, 1'b0, 1'b0, 8'd4};
      vecs[9]  = '{1'b0, 3'b110, 16'd0,    R9,       1'b1, 1'b1, 8'd5};
      vecs[10] = '{1'b0, 3'b001, 16'd1,    R10,      O10,  1'b1, 8'd6};
      vecs[11] = '{1'b0, 3'b010, 16'hFFF6, 16'd10,   1'b0, 1'b1, 8'd7};
      vecs[12] = '{1'b0, 3'b100, 16'd5,    16'd15,   1'b0, 1'b1, 8'd8};
      vecs[13] = '{1'b1, 3'b000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 8'd8};
      vecs[14] = '{1'b0, 3'b001, 16'h7FFF, 16'h8000, 1'b0, 1'b0, 8'd9};
      vecs[15] = '{1'b0, 3'b000, 16'hFFFF, R15,      1'b1, 1'b1, 8'd10};

      tick();
      tick();
      check_reset_values("reset");
      reset = 1'b0;

      for (int i = 0; i < NV; i++) run_cmd(i, vecs[i]);

      // Back-pressure: response held while a second command waits.
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 16'd42;
      tick();
      cmd_data = 16'd99;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d res_valid", i), 32'(res_valid), 1);
         chk($sformatf("stall%0d res_data", i), 32'(res_data), 42);
         chk($sformatf("stall%0d cmd_ready", i), 32'(cmd_ready), 0);
         $display("stall cycle %0d: res_valid=%0b res_data=%h cmd_ready=%0b",
                  i, res_valid, res_data, cmd_ready);
         tick();
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("stall release res_valid", 32'(res_valid), 0);
      chk("stall release cmd_ready", 32'(cmd_ready), 1);
      chk("stall second cmd dropped", 32'(acc), 42);

      // Reset while the calculator operation is in EXEC.
      cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'b000; cmd_data = 16'd3;
      tick();
      cmd_valid = 1'b0;
      chk("exec calc_a", 32'(calc_a), 42);
      chk("exec res_valid", 32'(res_valid), 0);
      reset = 1'b1;
      tick();
      $display("reset in EXEC: acc=%h op_count=%0d res_valid=%0b", acc, op_count, res_valid);
      check_reset_values("exec reset");
      reset = 1'b0;
      tick();
      chk("after reset idle res_valid", 32'(res_valid), 0);

      // Saturation mux on its own.
      s_ovf = 1'b0; s_abs = 1'b0; s_r = 16'h1234; #1;
      chk("sat pass", 32'(s_val), 32'h1234);
      s_ovf = 1'b1; s_abs = 1'b0; s_r = 16'h8000; #1;
      chk("sat pos", 32'(s_val), 32'h7FFF);
      s_ovf = 1'b1; s_abs = 1'b0; s_r = 16'h7FFF; #1;
      chk("sat neg", 32'(s_val), 32'h8000);
      s_ovf = 1'b1; s_abs = 1'b1; s_r = 16'h0000; #1;
      chk("sat abs", 32'(s_val), 32'h7FFF);
      $display("sat mux: r=%h abs=%0b ovf=%0b -> %h", s_r, s_abs, s_ovf, s_val);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
